// File: rtl/shift_rows_pipe_pkg.sv
// Shared AES helpers: block-width legality, ShiftRows row offsets and the
// count encoding of the two-entry output buffer.
package shift_rows_pipe_pkg;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } fifo_cnt_e;

  // Rijndael supports 4, 6 or 8 state columns.
  function automatic bit nb_legal(int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Row offset C(r). Only the 256-bit block shifts rows 2 and 3 one further.
  function automatic int row_shift(int nb, int r);
    if (r == 0) return 0;
    if ((nb == 8) && (r >= 2)) return r + 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Valid/ready stream bundle around the ShiftRows stage: input beat with mode
// bit and tag, output beat with tag.
interface shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [32*NB-1:0]    in_data;
  logic                in_inv;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [32*NB-1:0]    out_data;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation. Byte k = r + 4c
// sits at state[W-1-8k -: 8]; the column index wraps modulo NB.
module shift_rows_perm
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state,
  input  logic             inv,
  output logic [32*NB-1:0] permuted
);
  localparam int W = 32 * NB;

  logic [W-1:0] fwd_state;
  logic [W-1:0] inv_state;

  // Both directions are pure wiring; the mode bit only selects between them.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SRC_F = (c + row_shift(NB, r)) % NB;
      localparam int SRC_I = (c + NB - row_shift(NB, r)) % NB;
      assign fwd_state[W-1-8*(r+4*c) -: 8] = state[W-1-8*(r+4*SRC_F) -: 8];
      assign inv_state[W-1-8*(r+4*c) -: 8] = state[W-1-8*(r+4*SRC_I) -: 8];
    end
  end

  // Select the permutation requested for this beat.
  always_comb begin
    permuted = inv ? inv_state : fwd_state;
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered, flow-controlled ShiftRows stage. The permutation is applied on
// the way into a two-entry buffer so in_ready depends on registered state only.
//
// count     | meaning
// ----------+--------------------------------------------------
// CNT_EMPTY | no beat held, out_valid low
// CNT_ONE   | head valid, room for one more beat
// CNT_FULL  | head and tail valid, in_ready low
module shift_rows_pipe
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  shift_rows_pipe_if.slave   bus
);
  localparam int W = 32 * NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  fifo_cnt_e        count;
  logic [W-1:0]     head_data;
  logic [TAG_W-1:0] head_tag;
  logic [W-1:0]     tail_data;
  logic [TAG_W-1:0] tail_tag;
  logic [W-1:0]     perm_data;
  logic             push;
  logic             pop;

  shift_rows_perm #(.NB(NB)) u_perm (
    .state    (bus.in_data),
    .inv      (bus.in_inv),
    .permuted (perm_data)
  );

  assign bus.in_ready  = (count != CNT_FULL) && !rst;
  assign bus.out_valid = (count != CNT_EMPTY);
  assign bus.out_data  = head_data;
  assign bus.out_tag   = head_tag;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Buffer occupancy and entry updates; the head only changes on a pop or
  // when the buffer was empty, so the outputs hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= CNT_EMPTY;
      head_data <= '0;
      head_tag  <= '0;
      tail_data <= '0;
      tail_tag  <= '0;
    end else begin
      case (count)
        CNT_EMPTY: begin
          if (push) begin
            head_data <= perm_data;
            head_tag  <= bus.in_tag;
            count     <= CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            head_data <= perm_data;
            head_tag  <= bus.in_tag;
          end else if (push) begin
            tail_data <= perm_data;
            tail_tag  <= bus.in_tag;
            count     <= CNT_FULL;
          end else if (pop) begin
            count <= CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            head_data <= tail_data;
            head_tag  <= tail_tag;
            count     <= CNT_ONE;
          end
        end
        default: count <= CNT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe at NB=4 and NB=8 with a scoreboard of
// independently permuted expected beats.
module tb_shift_rows_pipe;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   tag;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  shift_rows_pipe_if #(.NB(4), .TAG_W(4)) b4 ();
  shift_rows_pipe_if #(.NB(8), .TAG_W(4)) b8 ();

  shift_rows_pipe #(.NB(4), .TAG_W(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  shift_rows_pipe #(.NB(8), .TAG_W(4)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   pops4 = 0;
  bit   lat_on = 1'b0;
  exp_t q4[$];
  exp_t q8[$];

  // Reference ShiftRows written from the row-offset table.
  function automatic logic [255:0] model(logic [255:0] d, int nb, bit inv);
    int           off[4];
    int           w;
    int           src;
    logic [255:0] o;
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    w = 32 * nb;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) begin
        src = inv ? ((c - off[r] + nb) % nb) : ((c + off[r]) % nb);
        o[w-1-8*(r+4*c) -: 8] = d[w-1-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  task automatic chk(string name, logic [255:0] obs, logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock: score pops and record accepts at the negedge, return after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (b4.out_valid && b4.out_ready) begin
      tests++;
      assert (q4.size() > 0) else begin
        fails++;
        $error("FAIL nb4_unexpected_beat: observed tag %0h expected no beat", b4.out_tag);
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("nb4_data", {128'b0, b4.out_data}, e.data);
        chk("nb4_tag", 256'(b4.out_tag), 256'(e.tag));
        if (lat_on) chk("nb4_latency", 256'(cyc - e.acc), 256'(1));
        pops4++;
      end
    end
    if (b8.out_valid && b8.out_ready) begin
      tests++;
      assert (q8.size() > 0) else begin
        fails++;
        $error("FAIL nb8_unexpected_beat: observed tag %0h expected no beat", b8.out_tag);
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("nb8_data", b8.out_data, e.data);
        chk("nb8_tag", 256'(b8.out_tag), 256'(e.tag));
      end
    end
    if (b4.in_valid && b4.in_ready) begin
      e.data = model({128'b0, b4.in_data}, 4, b4.in_inv);
      e.tag  = b4.in_tag;
      e.acc  = cyc;
      q4.push_back(e);
    end
    if (b8.in_valid && b8.in_ready) begin
      e.data = model(b8.in_data, 8, b8.in_inv);
      e.tag  = b8.in_tag;
      e.acc  = cyc;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [255:0] seq8;
  logic [255:0] out8;

  initial begin
    rst = 1'b1;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_inv = 1'b0; b4.in_tag = '0; b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_inv = 1'b0; b8.in_tag = '0; b8.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 256'(b4.out_valid), 256'(0));
    chk("rst_out_data", {128'b0, b4.out_data}, 256'(0));
    chk("rst_out_tag", 256'(b4.out_tag), 256'(0));
    chk("rst_in_ready", 256'(b4.in_ready), 256'(0));
    rst = 1'b0;
    #1;
    chk("release_in_ready", 256'(b4.in_ready), 256'(1));

    // FIPS-197 round 1 forward, then its inverse
    b4.out_ready = 1'b1;
    b4.in_valid = 1'b1; b4.in_inv = 1'b0; b4.in_tag = 4'd5;
    b4.in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
    tick();
    b4.in_valid = 1'b0;
    chk("fips_fwd_valid", 256'(b4.out_valid), 256'(1));
    chk("fips_fwd_data", {128'b0, b4.out_data}, {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
    chk("fips_fwd_tag", 256'(b4.out_tag), 256'(5));
    tick();
    b4.in_valid = 1'b1; b4.in_inv = 1'b1; b4.in_tag = 4'd6;
    b4.in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    tick();
    b4.in_valid = 1'b0;
    chk("fips_inv_data", {128'b0, b4.out_data}, {128'b0, 128'hd42711aee0bf98f1b8b45de51e415230});
    tick();
    chk("fips_drained", 256'(b4.out_valid), 256'(0));

    // NB=8 wrap modulo 8, then inverse round-trip
    for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = 8'(k);
    b8.out_ready = 1'b1;
    b8.in_valid = 1'b1; b8.in_inv = 1'b0; b8.in_tag = 4'd3; b8.in_data = seq8;
    tick();
    b8.in_valid = 1'b0;
    out8 = b8.out_data;
    chk("nb8_byte2", 256'(out8[255-16 -: 8]), 256'(8'h0e));
    chk("nb8_byte3", 256'(out8[255-24 -: 8]), 256'(8'h13));
    chk("nb8_byte31", 256'(out8[255-248 -: 8]), 256'(8'h0f));
    tick();
    b8.in_valid = 1'b1; b8.in_inv = 1'b1; b8.in_tag = 4'd4; b8.in_data = out8;
    tick();
    b8.in_valid = 1'b0;
    chk("nb8_roundtrip", b8.out_data, seq8);
    tick();

    // Backpressure: three beats offered with out_ready low
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1; b4.in_inv = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      b4.in_tag = 4'(i);
      b4.in_data = {$urandom, $urandom, $urandom, $urandom};
      chk("bp_in_ready", 256'(b4.in_ready), (i == 3) ? 256'(0) : 256'(1));
      tick();
      if (i == 3) chk("bp_still_full", 256'(b4.in_ready), 256'(0));
    end
    b4.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("bp_stream_valid", 256'(b4.out_valid), 256'(1));
      chk("bp_order_tag", 256'(b4.out_tag), 256'(i));
      tick();
      if (i == 2) b4.in_valid = 1'b0;
    end
    chk("bp_drained", 256'(b4.out_valid), 256'(0));

    // Streaming: 16 beats, alternating mode, out_ready high
    pops4 = 0;
    lat_on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b4.in_valid = 1'b1;
      b4.in_inv = 1'(i % 2);
      b4.in_tag = 4'(i);
      b4.in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    b4.in_valid = 1'b0;
    tick();
    lat_on = 1'b0;
    chk("stream_count", 256'(pops4), 256'(16));
    chk("stream_queue_empty", 256'(q4.size()), 256'(0));

    // Reset while FULL
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1; b4.in_inv = 1'b0;
    b4.in_tag = 4'd6; b4.in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    b4.in_tag = 4'd7; b4.in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    chk("full_in_ready", 256'(b4.in_ready), 256'(0));
    rst = 1'b1;
    b4.in_tag = 4'd8;
    #1;
    chk("rst_hi_in_ready", 256'(b4.in_ready), 256'(0));
    tick();
    q4.delete();
    chk("midrst_out_valid", 256'(b4.out_valid), 256'(0));
    chk("midrst_out_data", {128'b0, b4.out_data}, 256'(0));
    chk("midrst_in_ready", 256'(b4.in_ready), 256'(0));
    tick();
    chk("midrst_no_accept", 256'(q4.size()), 256'(0));
    rst = 1'b0;
    b4.out_ready = 1'b1;
    b4.in_tag = 4'd9; b4.in_inv = 1'b1;
    b4.in_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("post_rst_in_ready", 256'(b4.in_ready), 256'(1));
    tick();
    b4.in_valid = 1'b0;
    chk("post_rst_valid", 256'(b4.out_valid), 256'(1));
    chk("post_rst_tag", 256'(b4.out_tag), 256'(9));
    tick();
    chk("post_rst_drained", 256'(b4.out_valid), 256'(0));
    chk("post_rst_queue", 256'(q4.size()), 256'(0));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
